axi_lite_fifo_wr_arbiter: RTL
=============================

# axi_lite_fifo_wr_arbiter

Round-robin arbiter and AXI4-Lite master that shares the AXI write port of `axi_lite_async_fifo` among `NUM_REQ` local requesters in the `clk_axi` domain. Each requester presents one 32-bit word. The block grants one requester at a time and performs a single-beat AW/W/B write to the FIFO data address. It then returns the write response to the granted requester. Optionally, it polls the FIFO status register first so that no write is issued into a full FIFO.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 4: AXI address width.
- `DATA_WIDTH`, 32: AXI data width.
- `FIFO_ADDR`, 4'h0: write (push) address.
- `STATUS_ADDR`, 4'h0: status read address. Bit0 = empty, bit1 = full.
- `POLL_GAP`, 8: idle cycles between status polls while full, 1..255.

Ports:
- `clk_axi` in 1: single clock.
- `axi_reset_i` in 1: synchronous, active-high reset.
- `req_i` in NUM_REQ: per-requester write request. Held until `gnt_o` bit.
- `req_data_i` in NUM_REQ*DATA_WIDTH: word k at `[k*DW +: DW]`.
- `gnt_o` out NUM_REQ: one-hot, 1-cycle pulse. Data captured.
- `done_o` out NUM_REQ: one-hot, 1-cycle pulse. Write completed.
- `resp_o` out 2: BRESP of the completed write. Valid with `done_o`.
- `busy_o` out 1: FSM not in IDLE.
- `axi_awaddr_o`, `axi_awvalid_o`, `axi_awready_i`: AW channel.
- `axi_wdata_o`, `axi_wstrb_o` (4), `axi_wvalid_o`, `axi_wready_i`: W channel.
- `axi_bresp_i` (2), `axi_bvalid_i`, `axi_bready_o`: B channel.
- `axi_araddr_o`, `axi_arvalid_o`, `axi_arready_i`: AR channel.
- `axi_rdata_i`, `axi_rresp_i` (2), `axi_rvalid_i`, `axi_rready_o`: R channel.

## Operation

- FSM states: IDLE, POLL_AR, POLL_R, POLL_WAIT, WRITE, RESP.
- **IDLE.** If any `req_i` bit is set, pick the first set bit at or after `rr_ptr`, wrapping modulo `NUM_REQ`. On that edge:
  - latch index and data;
  - pulse `gnt_o[idx]` for the next cycle;
  - set `rr_ptr = idx+1`, wrapping `NUM_REQ-1 -> 0`;
  - go to POLL_AR when the macro is defined, otherwise WRITE.
- **WRITE.**
  - `axi_awvalid_o` and `axi_wvalid_o` rise together, with `awaddr = FIFO_ADDR`, `wdata` = latched word, `wstrb = 4'hF`.
  - Each valid drops independently on the cycle after its own ready is sampled high. AW and W may complete in either order or together.
  - When both have completed, go to RESP.
- **RESP.**
  - `axi_bready_o = 1`.
  - On `axi_bvalid_i`: capture `axi_bresp_i`, pulse `done_o[idx]` with `resp_o` for one cycle, return to IDLE.
  - SLVERR is passed through. No retry.
- **Valid rules.** AXI valids never drop before their handshake.
- **Payload stability.** Address, data and strobe are stable while their valid is high.
- **Arbitration.** Requests arriving while busy wait. Round-robin guarantees each waiting requester is served within `NUM_REQ` transactions.
- **Grant with request dropped.** A `req_i` bit that drops after grant has no effect.

## Timing

- **Reset values.** Every output is 0: all valids, readies, `gnt_o`, `done_o`, `resp_o`, `busy_o`, address, data and `wstrb`. Also `rr_ptr = 0` and FSM = IDLE.
- **Reset mid-transaction.** The block returns to IDLE on the next edge. No `done_o` is produced for the aborted write.
- **Request to write.**
  - `req_i` sampled high in IDLE at edge t: `gnt_o` and `axi_awvalid_o`/`axi_wvalid_o` are high in cycle t+1 when the macro is absent.
  - Best case with zero-wait slave ready: `done_o` in cycle t+3.
- **Back-to-back.** One IDLE cycle between `done_o` and the next grant.
- **Poll counter.** 8 bits. Loads `POLL_GAP` and counts down to 0.

## Configuration

- `FIFO_STATUS_POLL_EN` defined:
  - After grant, POLL_AR asserts `axi_arvalid_o` with `araddr = STATUS_ADDR` until `axi_arready_i`.
  - POLL_R holds `axi_rready_o = 1` until `axi_rvalid_i`.
  - If `rresp == 2'b00` and `rdata[1] == 0`, go to WRITE.
  - Otherwise go to POLL_WAIT for `POLL_GAP` cycles, then back to POLL_AR. Retries are unbounded.
- Undefined:
  - POLL states are not built.
  - `axi_arvalid_o`, `axi_rready_o` and `axi_araddr_o` are tied 0.
  - IDLE goes directly to WRITE, and back-pressure relies on the slave's AWREADY/WREADY.

## Test plan

- **Single request.** `req_i[2]=1`, data 0xDEADBEEF, slave ready immediately. Expect `gnt_o=4'b0100` one cycle later, AW+W at 0x0 with 0xDEADBEEF and `wstrb` 0xF, then `done_o=4'b0100`, `resp_o=00`.
- **Round-robin.** All four `req_i` held continuously. Expect grants in order 0,1,2,3,0 with one `done_o` per grant and one IDLE cycle between.
- **Skewed handshake.** WREADY 3 cycles before AWREADY. Expect `wvalid` low after its handshake, `awvalid` held, exactly one B accepted. Repeat with AWREADY first.
- **Error pass-through.** Slave returns BRESP=2'b10 for data 0xFEEDCAFE. Expect `done_o` with `resp_o=10`, no reissue.
- **Reset mid-operation.** `axi_reset_i` pulsed during RESP. Expect all outputs 0 the next cycle, no `done_o`, `rr_ptr=0`.
- **Full back-pressure (`FIFO_STATUS_POLL_EN`).** Status reads return 0x2 three times, then 0x0. Expect 4 AR transactions spaced `POLL_GAP`+ cycles apart, no AWVALID before the 4th R, then a normal write.

Source files
------------

// File: rtl/axi_lite_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_fifo_wr_arbiter
//
// Round-robin arbiter plus single-beat AXI4-Lite write master. NUM_REQ local
// requesters share the AXI write port of an async FIFO. The block grants one
// requester at a time and pushes its 32-bit word to FIFO_ADDR. It then hands
// the B response back to that requester.
//
// Optional feature macro: FIFO_STATUS_POLL_EN
//   When defined, the FIFO status register (bit1 = full) is read after each
//   grant. The write is only issued once the FIFO is not full, and the status
//   is re-polled every POLL_GAP cycles while it stays full. When undefined, the
//   AR/R channel outputs are tied to 0, and back-pressure comes only from the
//   slave's AWREADY/WREADY.
//
// Ports
//   clk_axi                    : clock
//   axi_reset_i                : synchronous active-high reset
//   req_i / req_data_i         : per-requester request and data word
//   gnt_o                      : one-hot 1-cycle pulse, data captured
//   done_o / resp_o            : one-hot 1-cycle pulse with BRESP of the write
//   busy_o                     : FSM not idle
//   axi_aw* / axi_w* / axi_b*  : AXI4-Lite write channels
//   axi_ar* / axi_r*           : AXI4-Lite read channels (status polling)
// -----------------------------------------------------------------------------
module axi_lite_fifo_wr_arbiter #(
    parameter int                    NUM_REQ     = 4,
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] FIFO_ADDR   = 4'h0,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 4'h0,
    parameter int                    POLL_GAP    = 8
) (
    input  logic                          clk_axi,
    input  logic                          axi_reset_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [1:0]                    resp_o,
    output logic                          busy_o,
    output logic [ADDR_WIDTH-1:0]         axi_awaddr_o,
    output logic                          axi_awvalid_o,
    input  logic                          axi_awready_i,
    output logic [DATA_WIDTH-1:0]         axi_wdata_o,
    output logic [3:0]                    axi_wstrb_o,
    output logic                          axi_wvalid_o,
    input  logic                          axi_wready_i,
    input  logic [1:0]                    axi_bresp_i,
    input  logic                          axi_bvalid_i,
    output logic                          axi_bready_o,
    output logic [ADDR_WIDTH-1:0]         axi_araddr_o,
    output logic                          axi_arvalid_o,
    input  logic                          axi_arready_i,
    input  logic [DATA_WIDTH-1:0]         axi_rdata_i,
    input  logic [1:0]                    axi_rresp_i,
    input  logic                          axi_rvalid_i,
    output logic                          axi_rready_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_POLL_AR   = 3'd1,
        ST_POLL_R    = 3'd2,
        ST_POLL_WAIT = 3'd3,
        ST_WRITE     = 3'd4,
        ST_RESP      = 3'd5
    } state_e;

    state_e                  state_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [3:0]              wstrb_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic [NUM_REQ-1:0]      gnt_q;
    logic [NUM_REQ-1:0]      done_q;
    logic [1:0]              resp_q;
    logic                    busy_q;

    logic                    any_req_d;
    logic [IDX_W-1:0]        pick_d;
    logic [IDX_W-1:0]        next_ptr_d;
    logic [DATA_WIDTH-1:0]   pick_data_d;
    logic [SUM_W-1:0]        cand_sum_d;
    logic [IDX_W-1:0]        cand_d;

`ifdef FIFO_STATUS_POLL_EN
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic [7:0]              poll_cnt_q;
`endif

    // Round-robin selection: first asserted request at or after rr_ptr_q, wrapping.
    always_comb begin
        any_req_d   = 1'b0;
        pick_d      = '0;
        cand_sum_d  = '0;
        cand_d      = '0;
        pick_data_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum_d = {1'b0, rr_ptr_q} + SUM_W'(i);
            if (cand_sum_d >= SUM_W'(NUM_REQ)) begin
                cand_sum_d = cand_sum_d - SUM_W'(NUM_REQ);
            end else begin
                cand_sum_d = cand_sum_d;
            end
            cand_d = cand_sum_d[IDX_W-1:0];
            if (!any_req_d && req_i[cand_d]) begin
                any_req_d = 1'b1;
                pick_d    = cand_d;
            end else begin
                any_req_d = any_req_d;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_d == IDX_W'(i)) begin
                pick_data_d = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                pick_data_d = pick_data_d;
            end
        end
        if (pick_d == IDX_W'(NUM_REQ - 1)) begin
            next_ptr_d = '0;
        end else begin
            next_ptr_d = pick_d + IDX_W'(1);
        end
    end

    // Transaction FSM with all AXI and requester-side outputs registered.
    always_ff @(posedge clk_axi) begin
        if (axi_reset_i) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            awaddr_q   <= '0;
            wstrb_q    <= 4'h0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            resp_q     <= 2'b00;
            busy_q     <= 1'b0;
`ifdef FIFO_STATUS_POLL_EN
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            poll_cnt_q <= 8'd0;
`endif
        end else begin
            // Pulses last exactly one cycle.
            gnt_q  <= '0;
            done_q <= '0;
            resp_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (any_req_d) begin
                        idx_q    <= pick_d;
                        wdata_q  <= pick_data_d;
                        awaddr_q <= FIFO_ADDR;
                        wstrb_q  <= 4'hF;
                        gnt_q    <= ONE_HOT_LSB << pick_d;
                        rr_ptr_q <= next_ptr_d;
                        busy_q   <= 1'b1;
`ifdef FIFO_STATUS_POLL_EN
                        araddr_q  <= STATUS_ADDR;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_POLL_AR;
`else
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= ST_WRITE;
`endif
                    end
                end
`ifdef FIFO_STATUS_POLL_EN
                ST_POLL_AR: begin
                    if (axi_arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_POLL_R;
                    end
                end
                ST_POLL_R: begin
                    if (axi_rvalid_i) begin
                        rready_q <= 1'b0;
                        // Only an OKAY read reporting "not full" releases the write.
                        if ((axi_rresp_i == 2'b00) && !axi_rdata_i[1]) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WRITE;
                        end else begin
                            poll_cnt_q <= 8'(POLL_GAP);
                            state_q    <= ST_POLL_WAIT;
                        end
                    end
                end
                ST_POLL_WAIT: begin
                    poll_cnt_q <= poll_cnt_q - 8'd1;
                    // Leaves as the counter reaches 0, giving POLL_GAP idle cycles.
                    if (poll_cnt_q <= 8'd1) begin
                        poll_cnt_q <= 8'd0;
                        arvalid_q  <= 1'b1;
                        state_q    <= ST_POLL_AR;
                    end
                end
`endif
                ST_WRITE: begin
                    if (awvalid_q && axi_awready_i) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && axi_wready_i) begin
                        wvalid_q <= 1'b0;
                    end
                    // Each channel is complete once its valid is low or handshaking now.
                    if ((!awvalid_q || axi_awready_i) && (!wvalid_q || axi_wready_i)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (axi_bvalid_i) begin
                        bready_q <= 1'b0;
                        done_q   <= ONE_HOT_LSB << idx_q;
                        resp_q   <= axi_bresp_i;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o         = gnt_q;
    assign done_o        = done_q;
    assign resp_o        = resp_q;
    assign busy_o        = busy_q;
    assign axi_awaddr_o  = awaddr_q;
    assign axi_awvalid_o = awvalid_q;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_bready_o  = bready_q;

`ifdef FIFO_STATUS_POLL_EN
    assign axi_araddr_o  = araddr_q;
    assign axi_arvalid_o = arvalid_q;
    assign axi_rready_o  = rready_q;
`else
    assign axi_araddr_o  = '0;
    assign axi_arvalid_o = 1'b0;
    assign axi_rready_o  = 1'b0;
`endif

    // Read-channel inputs and poll settings have no sink in every build.
    logic unused_in;
    assign unused_in = ^{axi_arready_i, axi_rdata_i, axi_rresp_i, axi_rvalid_i,
                         STATUS_ADDR, POLL_GAP[7:0]};

endmodule
